// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI byte engine among NREQ requesters,
// sequencing multi-byte bursts per grant with chip selects, byte acks and a done watchdog.
module spi_bus_arbiter #(
   parameter int N        = 8,
   parameter int NREQ     = 2,
   parameter int MAXBYTES = 4,
   parameter int TIMEOUT  = 32
) (
   input  logic                sclk,
   input  logic                n_reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     wr_en,
   input  logic [NREQ-1:0]     last,
   input  logic [NREQ*N-1:0]   wdata,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     cs_n,
   output logic [NREQ-1:0]     byte_ack,
   output logic [N-1:0]        rdata,
   output logic                err,
   output logic                spi_start,
   output logic                spi_write,
   output logic [N-1:0]        spi_pdatain,
   input  logic                spi_done,
   input  logic [N-1:0]        spi_pdataout
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAXBYTES + 1);
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, ACK, HOLD} state_t;

   state_t            r_state;
   logic [IW-1:0]     r_rr;
   logic [IW-1:0]     r_w;
   logic [CW-1:0]     r_cnt;
   logic [WW-1:0]     r_wd;
   logic              r_last;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_csN;
   logic [NREQ-1:0]   r_byteAck;
   logic [N-1:0]      r_rdata;
   logic              r_err;
   logic              r_spiStart;
   logic              r_spiWrite;
   logic [N-1:0]      r_spiPdatain;

   logic [IW-1:0]     w_win;
   logic [IW-1:0]     w_cand;
   logic              w_any;
   logic [NREQ-1:0]   w_winHot;
   logic [N-1:0]      w_wsel;

   // Round-robin search: first requester found scanning upward from the one after r_rr.
   always_comb begin
      w_win  = '0;
      w_any  = 1'b0;
      w_cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IW'((int'(r_rr) + k) % NREQ);
         if (!w_any && req[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
   end

   assign w_winHot = NREQ'(1) << w_win;

   always_comb begin
      w_wsel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_w == IW'(i)) begin
            w_wsel = wdata[i*N +: N];
         end
      end
   end

   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         r_state      <= IDLE;
         r_rr         <= IW'(NREQ - 1);
         r_w          <= '0;
         r_cnt        <= '0;
         r_wd         <= '0;
         r_last       <= 1'b0;
         r_gnt        <= '0;
         r_csN        <= '1;
         r_byteAck    <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         r_spiStart   <= 1'b0;
         r_spiWrite   <= 1'b0;
         r_spiPdatain <= '0;
      end else begin
         r_byteAck  <= '0;
         r_err      <= 1'b0;
         r_spiStart <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_w     <= w_win;
                  r_cnt   <= '0;
                  r_gnt   <= w_winHot;
                  r_csN   <= ~w_winHot;
                  r_state <= SETUP;
               end
            end
            // Byte fields are sampled on the edge entering ISSUE so the engine sees them registered.
            SETUP, ACK: begin
               if (r_state == ACK && (r_last || r_cnt == CW'(MAXBYTES))) begin
                  r_state <= HOLD;
               end else begin
                  r_spiStart   <= 1'b1;
                  r_spiWrite   <= wr_en[r_w];
                  r_spiPdatain <= w_wsel;
                  r_last       <= last[r_w];
                  r_wd         <= '0;
                  if (r_cnt != CW'(MAXBYTES)) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
            end
            // Abort fires as the watchdog would step to TIMEOUT-1, so err lands TIMEOUT cycles after ISSUE.
            WAIT: begin
               if (spi_done) begin
                  r_rdata   <= spi_pdataout;
                  r_byteAck <= r_gnt;
                  r_state   <= ACK;
               end else if (r_wd == WW'(TIMEOUT - 2)) begin
                  r_err   <= 1'b1;
                  r_state <= HOLD;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            HOLD: begin
               r_rr    <= r_w;
               r_gnt   <= '0;
               r_csN   <= '1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign cs_n        = r_csN;
   assign byte_ack    = r_byteAck;
   assign rdata       = r_rdata;
   assign err         = r_err;
   assign spi_start   = r_spiStart;
   assign spi_write   = r_spiWrite;
   assign spi_pdatain = r_spiPdatain;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenarios plus randomized traffic against a timestamp-based
// behavioural model of the arbiter, with an engine responder model driving spi_done.
module tb_spi_bus_arbiter;

   localparam int N        = 8;
   localparam int NREQ     = 2;
   localparam int MAXBYTES = 4;
   localparam int TIMEOUT  = 32;
   localparam int WD       = NREQ * N;
   localparam int INF      = 1 << 30;

   logic              sclk = 1'b0;
   logic              n_reset;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   wr_en;
   logic [NREQ-1:0]   last;
   logic [WD-1:0]     wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   cs_n;
   logic [NREQ-1:0]   byte_ack;
   logic [N-1:0]      rdata;
   logic              err;
   logic              spi_start;
   logic              spi_write;
   logic [N-1:0]      spi_pdatain;
   logic              spi_done = 1'b0;
   logic [N-1:0]      spi_pdataout = '0;

   spi_bus_arbiter #(.N(N), .NREQ(NREQ), .MAXBYTES(MAXBYTES), .TIMEOUT(TIMEOUT)) dut (
      .sclk(sclk), .n_reset(n_reset), .req(req), .wr_en(wr_en), .last(last), .wdata(wdata),
      .gnt(gnt), .cs_n(cs_n), .byte_ack(byte_ack), .rdata(rdata), .err(err),
      .spi_start(spi_start), .spi_write(spi_write), .spi_pdatain(spi_pdatain),
      .spi_done(spi_done), .spi_pdataout(spi_pdataout)
   );

   always #5 sclk = ~sclk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
      end
   endtask

   // Reference model: each burst is tracked by the cycle numbers of its grant, current issue,
   // current ack and hold; expected outputs are pure functions of those stamps.
   int          mOwner = -1;
   int          mSetup = -1;
   int          mIssue = -1;
   int          mAck = -1;
   int          mHold = INF;
   int          mBytes = 0;
   int          mRr = NREQ - 1;
   int          mFreeFrom = 0;
   bit          mLast = 0;
   bit          mAbort = 0;
   bit          mWrite = 0;
   logic [N-1:0] mData = '0;
   logic [N-1:0] mRdata = '0;

   task automatic modelStep();
      int prev;
      int w;
      prev = cyc - 1;
      if (mOwner < 0) begin
         if (prev >= mFreeFrom && req != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               if (w < 0 && req[(mRr + k) % NREQ]) w = (mRr + k) % NREQ;
            end
            mOwner = w; mSetup = cyc; mIssue = -1; mAck = -1; mHold = INF;
            mBytes = 0; mAbort = 0;
         end
      end else if (prev == mHold) begin
         mRr = mOwner; mOwner = -1; mFreeFrom = cyc;
      end else if (prev == mSetup || (prev == mAck && mAck > mIssue)) begin
         if (prev == mAck && (mLast || mBytes >= MAXBYTES)) begin
            mHold = cyc;
         end else begin
            mIssue = cyc;
            mWrite = wr_en[mOwner];
            mData  = wdata[mOwner*N +: N];
            mLast  = last[mOwner];
            mBytes++;
         end
      end else if (mIssue >= 0 && prev > mIssue && mAck < mIssue) begin
         if (spi_done) begin
            mAck = cyc; mRdata = spi_pdataout;
         end else if (cyc == mIssue + TIMEOUT) begin
            mHold = cyc; mAbort = 1;
         end
      end
   endtask

   always @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         mOwner = -1; mIssue = -1; mAck = -1; mHold = INF; mRr = NREQ - 1;
         mFreeFrom = 0; mRdata = '0; mAbort = 0; mBytes = 0; mLast = 0;
      end else begin
         cyc++;
         modelStep();
      end
   end

   // Compare process: every negedge, DUT outputs against the model (or reset values).
   always @(negedge sclk) begin
      int expGnt;
      expGnt = (mOwner >= 0) ? (1 << mOwner) : 0;
      if (!n_reset) begin
         checkOutput("rst.gnt", 32'(gnt), 32'd0);
         checkOutput("rst.cs_n", 32'(cs_n), 32'((1 << NREQ) - 1));
         checkOutput("rst.byte_ack", 32'(byte_ack), 32'd0);
         checkOutput("rst.err", 32'(err), 32'd0);
         checkOutput("rst.spi_start", 32'(spi_start), 32'd0);
         checkOutput("rst.spi_write", 32'(spi_write), 32'd0);
         checkOutput("rst.spi_pdatain", 32'(spi_pdatain), 32'd0);
         checkOutput("rst.rdata", 32'(rdata), 32'd0);
      end else begin
         checkOutput("gnt", 32'(gnt), 32'(expGnt));
         checkOutput("cs_n", 32'(cs_n), 32'(~expGnt & ((1 << NREQ) - 1)));
         checkOutput("spi_start", 32'(spi_start), 32'(mOwner >= 0 && cyc == mIssue));
         checkOutput("byte_ack", 32'(byte_ack), 32'((mOwner >= 0 && cyc == mAck) ? expGnt : 0));
         checkOutput("err", 32'(err), 32'(mOwner >= 0 && mAbort && cyc == mHold));
         checkOutput("rdata", 32'(rdata), 32'(mRdata));
         if (mOwner >= 0 && mIssue >= 0) begin
            checkOutput("spi_write", 32'(spi_write), 32'(mWrite));
            checkOutput("spi_pdatain", 32'(spi_pdatain), 32'(mData));
         end
      end
   end

   // Engine responder: done after a chosen latency, never (watchdog case), or spurious when idle.
   int          engMinLat = 1;
   int          engMaxLat = 4;
   int          engNeverPct = 0;
   int          engSpurPct = 0;
   bit          engFixedEn = 0;
   logic [N-1:0] engFixedData = '0;
   bit          engBusy = 0;
   int          engDoneAt = -1;

   always @(negedge sclk) begin
      if (!n_reset) begin
         engBusy  = 0;
         spi_done = 1'b0;
      end else begin
         spi_done = 1'b0;
         if (spi_start) begin
            engBusy   = 1;
            engDoneAt = ($urandom_range(0, 99) < engNeverPct) ? -1 :
                        cyc + int'($urandom_range(engMinLat, engMaxLat));
         end
         if (engBusy && engDoneAt == cyc) begin
            spi_done     = 1'b1;
            spi_pdataout = engFixedEn ? engFixedData : N'($urandom);
            engBusy      = 0;
         end else if (engBusy && err) begin
            engBusy = 0;
         end else if (!engBusy && $urandom_range(0, 99) < engSpurPct) begin
            spi_done     = 1'b1;
            spi_pdataout = N'($urandom);
         end
      end
   end

   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                                input logic [NREQ-1:0] l, input logic [WD-1:0] d);
      req = r; wr_en = w; last = l; wdata = d;
   endtask

   task automatic waitFor(input string name, input int what, input int budget);
      bit hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge sclk);
         case (what)
            0: hit = spi_start;
            1: hit = (byte_ack != '0);
            2: hit = err;
            3: hit = (gnt != '0);
            default: hit = (gnt == '0);
         endcase
      end
      checkOutput({name, ".reached"}, 32'(hit), 32'd1);
   endtask

   initial begin
      logic [N-1:0]    bwData [3];
      logic [NREQ-1:0] rrExp [4];
      int issueCyc, acks, lastPct;
      bit hit;
      bwData = '{8'h11, 8'h22, 8'h33};
      rrExp  = '{2'b01, 2'b10, 2'b01, 2'b10};

      n_reset = 1'b0;
      applyStimulus('0, '0, '0, '0);
      repeat (3) @(negedge sclk);
      #2 n_reset = 1'b1;

      // Single read with a 3-cycle engine latency returning A5.
      engFixedEn = 1; engFixedData = 8'hA5; engMinLat = 3; engMaxLat = 3;
      @(negedge sclk);
      applyStimulus(2'b01, 2'b00, 2'b01, '0);
      @(negedge sclk);
      checkOutput("rd.gnt", 32'(gnt), 32'h1);
      checkOutput("rd.cs_n", 32'(cs_n), 32'h2);
      @(negedge sclk);
      checkOutput("rd.start", 32'(spi_start), 32'h1);
      checkOutput("rd.write", 32'(spi_write), 32'h0);
      repeat (4) @(negedge sclk);
      checkOutput("rd.ack", 32'(byte_ack), 32'h1);
      checkOutput("rd.rdata", 32'(rdata), 32'hA5);
      applyStimulus('0, '0, '0, '0);
      @(negedge sclk);
      checkOutput("rd.holdCs", 32'(cs_n), 32'h2);
      @(negedge sclk);
      checkOutput("rd.idleCs", 32'(cs_n), 32'h3);
      checkOutput("rd.idleGnt", 32'(gnt), 32'h0);

      // Three-byte write burst from requester 1.
      engFixedEn = 0; engMinLat = 1; engMaxLat = 4;
      applyStimulus(2'b10, 2'b10, 2'b00, {bwData[0], 8'h00});
      for (int b = 0; b < 3; b++) begin
         waitFor("bw.start", 0, 20);
         checkOutput("bw.data", 32'(spi_pdatain), 32'(bwData[b]));
         checkOutput("bw.write", 32'(spi_write), 32'h1);
         checkOutput("bw.cs_n", 32'(cs_n), 32'h1);
         waitFor("bw.ack", 1, 20);
         checkOutput("bw.ackBit", 32'(byte_ack), 32'h2);
         if (b < 2) applyStimulus(2'b10, 2'b10, (b == 1) ? 2'b10 : 2'b00, {bwData[b+1], 8'h00});
         else applyStimulus('0, '0, '0, '0);
      end
      waitFor("bw.idle", 4, 10);

      // Round-robin with both requesters holding single-byte bursts.
      applyStimulus(2'b11, NREQ'($urandom), 2'b11, WD'($urandom));
      for (int b = 0; b < 4; b++) begin
         waitFor("rr.grant", 3, 30);
         checkOutput("rr.order", 32'(gnt), 32'(rrExp[b]));
         waitFor("rr.gap", 4, 30);
         checkOutput("rr.gapCs", 32'(cs_n), 32'h3);
      end
      applyStimulus('0, '0, '0, '0);

      // MAXBYTES truncation with requester 1 pending.
      @(negedge sclk);
      applyStimulus(2'b11, 2'b00, 2'b00, WD'($urandom));
      acks = 0; hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge sclk);
         if (byte_ack[0]) acks++;
         if (gnt == 2'b10) hit = 1;
      end
      checkOutput("mx.acks0", 32'(acks), 32'd4);
      checkOutput("mx.next", 32'(gnt), 32'h2);
      applyStimulus('0, '0, '0, '0);
      waitFor("mx.idle", 4, 200);

      // Watchdog: engine never completes.
      engNeverPct = 100;
      applyStimulus(2'b01, 2'b01, 2'b01, WD'($urandom));
      waitFor("wd.start", 0, 20);
      issueCyc = cyc; acks = 0; hit = 0;
      for (int i = 0; i < TIMEOUT + 10 && !hit; i++) begin
         @(negedge sclk);
         if (byte_ack != '0) acks++;
         if (err) hit = 1;
      end
      engNeverPct = 0;
      checkOutput("wd.reached", 32'(hit), 32'd1);
      checkOutput("wd.latency", 32'(cyc - issueCyc), 32'(TIMEOUT));
      checkOutput("wd.noAck", 32'(acks), 32'd0);
      @(negedge sclk);
      checkOutput("wd.release", 32'(cs_n), 32'h3);
      waitFor("wd.next", 1, 60);
      checkOutput("wd.nextAck", 32'(byte_ack), 32'h1);
      applyStimulus('0, '0, '0, '0);
      waitFor("wd.idle", 4, 20);

      // Reset during WAIT; pointer must return so requester 0 wins.
      engMinLat = 8; engMaxLat = 8;
      applyStimulus(2'b11, 2'b00, 2'b11, WD'($urandom));
      waitFor("rs.start", 0, 20);
      checkOutput("rs.preGnt", 32'(gnt), 32'h2);
      @(negedge sclk);
      #2 n_reset = 1'b0;
      #1;
      checkOutput("rs.gnt", 32'(gnt), 32'h0);
      checkOutput("rs.cs_n", 32'(cs_n), 32'h3);
      checkOutput("rs.start", 32'(spi_start), 32'h0);
      repeat (2) @(negedge sclk);
      #2 n_reset = 1'b1;
      waitFor("rs.grant", 3, 10);
      checkOutput("rs.first", 32'(gnt), 32'h1);
      applyStimulus('0, '0, '0, '0);
      waitFor("rs.idle", 4, 60);

      // Randomized traffic checked by the compare process.
      engMinLat = 1; engMaxLat = 6; engNeverPct = 4; engSpurPct = 5;
      lastPct = 40;
      for (int c = 0; c < 4000; c++) begin
         @(negedge sclk);
         if (c % 500 == 0) lastPct = (c % 1500 == 0) ? 10 : ((c % 1000 == 0) ? 90 : 40);
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 99) < 15) req[i] = ~req[i];
            last[i] = ($urandom_range(0, 99) < lastPct);
         end
         wr_en = NREQ'($urandom);
         wdata = WD'($urandom);
         if ($urandom_range(0, 999) == 0) begin
            #2 n_reset = 1'b0;
            repeat (2) @(negedge sclk);
            #2 n_reset = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Shares one spi_interface byte engine between NREQ requesters. Requesters are granted in round-robin order. The block sequences multi-byte bursts per grant, drives a per-requester active-low chip select, and returns each received byte with a one-cycle acknowledge. A watchdog aborts a burst if the engine never reports done. It sits between the host-side clients and the spi_interface instance in the same sclk domain.

Parameters:
N, 8, byte width; matches the spi_interface data width.
NREQ, 2, number of requesters (2..8).
MAXBYTES, 4, maximum bytes per grant; the burst is force-ended after this count.
TIMEOUT, 32, sclk cycles to wait for spi_done before aborting.

Ports:
sclk  in  1  clock.
n_reset  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester transfer request; level-sensitive.
wr_en  in  NREQ  per-requester write flag for the current byte (1 = load wdata, 0 = shift-only read).
last  in  NREQ  per-requester flag marking the current byte as the final byte of the burst.
wdata  in  NREQ*N  flattened write data; requester i occupies bits [i*N +: N].
gnt  out  NREQ  one-hot grant, held for the whole burst.
cs_n  out  NREQ  active-low chip selects; at most one is low at any time.
byte_ack  out  NREQ  one-cycle pulse to the granted requester; rdata is valid in the same cycle.
rdata  out  N  last byte captured from the engine.
err  out  1  one-cycle pulse on watchdog abort.
spi_start  out  1  start strobe to the engine.
spi_write  out  1  write select to the engine.
spi_pdatain  out  N  parallel data to the engine.
spi_done  in  1  engine byte-complete pulse.
spi_pdataout  in  N  engine parallel receive data.

Behaviour:
- Reset (async, n_reset low):
  - state=IDLE, gnt=0, cs_n=all 1, byte_ack=0, err=0, spi_start=0, spi_write=0, spi_pdatain=0, rdata=0.
  - byte counter=0, watchdog=0, rr pointer=NREQ-1, so requester 0 wins first.
- Output style: Moore. gnt, cs_n, spi_start, spi_write, spi_pdatain, byte_ack and err are registered or decoded from the state register only; no combinational path from req to any output.
- FSM states: IDLE, SETUP, ISSUE, WAIT, ACK, HOLD.
- IDLE:
  - If any req bit is set, select the winner by searching from rr+1 upward with wrap.
  - Latch the winner index, clear the byte counter, go to SETUP.
  - If no req, stay in IDLE.
- SETUP (1 cycle): gnt[w]=1 and cs_n[w]=0. Next state is ISSUE.
- ISSUE (1 cycle):
  - Drive spi_start=1, spi_write=wr_en[w], spi_pdatain=wdata[w].
  - Latch last[w], increment the byte counter, clear the watchdog.
  - Next state is WAIT.
- WAIT:
  - spi_start=0; spi_write and spi_pdatain are held.
  - On spi_done: rdata<=spi_pdataout, go to ACK.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without done: pulse err, go to HOLD.
  - Abort takes priority only if done is absent in that cycle.
- ACK (1 cycle):
  - byte_ack[w]=1.
  - If latched last=1 or byte counter==MAXBYTES, go to HOLD; else go to ISSUE.
  - The requester must present its next wdata, wr_en and last by the ISSUE cycle that follows ACK.
- HOLD (1 cycle):
  - cs_n[w] stays low and gnt[w] stays high.
  - Update rr<=w, then go to IDLE, where cs_n returns to all 1 and gnt to 0.
- Ignored events:
  - req deasserting mid-burst has no effect; the burst ends only via last, MAXBYTES or abort.
  - A losing requester's req is held pending and is not lost.
  - A spi_done pulse outside WAIT is ignored.
- Minimum gap: one IDLE cycle, with all cs_n high, between consecutive bursts, even to the same requester.
- Latency:
  - req high in IDLE at cycle t gives gnt and cs_n low at t+1 and spi_start at t+2.
  - byte_ack occurs exactly 1 cycle after spi_done.
- Byte counter is $clog2(MAXBYTES+1) bits wide; it saturates logic, with no wrap inside a burst.
- Reset mid-burst: all outputs return to their reset values immediately (asynchronously); the burst is discarded with no byte_ack.

Test Plan:
- Single read: req[0]=1, wr_en=0, last=1; engine returns spi_done with spi_pdataout=8'hA5 3 cycles after start -> gnt=01, cs_n[0] low, one spi_start pulse with spi_write=0, byte_ack[0] with rdata=A5, cs_n high after HOLD.
- Burst write of 3 bytes: req[1], wdata=8'h11,22,33, last on the third byte -> three spi_start pulses with spi_pdatain 11,22,33 and spi_write=1, three byte_ack[1], cs_n[1] low continuously through the burst.
- Round-robin: req=11 held constant, each requester sends single-byte bursts -> grant order 0,1,0,1 with an IDLE cycle (cs_n=11) between bursts.
- MAXBYTES truncation: req[0] burst with last=0 forever, MAXBYTES=4 -> exactly 4 byte_acks, then HOLD, then IDLE; a pending req[1] is granted next.
- Watchdog: spi_done never asserted -> err pulses exactly TIMEOUT cycles after the ISSUE cycle, no byte_ack, cs_n released, next request served normally.
- Reset mid-WAIT: n_reset low during WAIT -> gnt=0, cs_n=all 1 and spi_start=0 the same cycle; after release, req[0] wins first.
